hilo_muldiv_ctrl: RTL and testbench
===================================

# hilo_muldiv_ctrl

Sequencer for the CPU's HI/LO multiply/divide unit. Accepts MULTU, DIV, DIVU, MTHI and MTLO operations from the execute stage and runs the iterative shift-add or shift-subtract datapath. It owns the architectural HI and LO registers and serves MFHI/MFLO reads. While an operation is in flight it raises a stall to the pipeline hazard logic, but only for instructions that touch HI/LO.

## Interface
Parameters:
- `XLEN`, 32, operand/HI/LO width
- `DIVZ_LO`, 32'hFFFF_FFFF, LO value written on divide-by-zero

Ports:
- `clk` in 1: rising-edge clock
- `rst_n` in 1: reset, asynchronous assert, active-low
- `start_multu`, `start_div`, `start_divu` in 1 each: operation request, sampled at clk edge
- `mthi`, `mtlo` in 1 each: write HI/LO from `rs_val`
- `rd_hi`, `rd_lo` in 1 each: MFHI/MFLO read request
- `rs_val`, `rt_val` in XLEN: operands (rs = dividend/multiplicand)
- `flush` in 1: exception/ERET cancel
- `hi`, `lo` out XLEN: architectural registers
- `rdata` out XLEN: `hi` when `rd_hi`, `lo` when `rd_lo`, else 0 (combinational)
- `busy` out 1: operation in flight
- `stall` out 1: `busy & (any start | mthi | mtlo | rd_hi | rd_lo)` (combinational)
- `done` out 1: one-cycle pulse after HI/LO are written by an operation

## Operation
- States: IDLE, MUL, DIV, FIX, and ZERO.
- Requests are accepted only in IDLE.
- Requests while busy are not accepted. They are held by `stall` and re-presented by the pipeline.
- Same-cycle priority: flush > start_div > start_divu > start_multu > mthi > mtlo.
- IDLE, mthi/mtlo: `hi`/`lo` <= `rs_val` at the next edge. The state stays IDLE and `done` is not pulsed.
- IDLE, start_multu: enter MUL. Run the 64-bit shift-add over 32 iterations using a 5-bit counter. At the end, HI = product[63:32] and LO = product[31:0].
- IDLE, start_divu or start_div with `rt_val` != 0: enter DIV.
  - DIV runs restoring division over 32 iterations on magnitudes.
  - start_div operands are converted to absolute values on entry.
  - DIVU ends by writing LO = quotient and HI = remainder.
  - DIV then takes one FIX cycle.
- FIX: the quotient is negated if the two operand signs differ, and the remainder takes the sign of the dividend. 0x80000000 / -1 yields LO = 0x80000000 and HI = 0 without special-casing.
- IDLE, start_div/start_divu with `rt_val` == 0: enter ZERO for 1 cycle. Writes LO = DIVZ_LO and HI = `rs_val`.
- Operands are latched at acceptance, so later changes to `rs_val`/`rt_val` have no effect.
- flush in any state: go to IDLE at the next edge. HI/LO are unchanged and `done` is not pulsed. A flush on the completion edge wins, so no write occurs.
- Reset: state IDLE, `hi` = `lo` = 0, `busy` = 0, `done` = 0, counter = 0. `stall` = 0 and `rdata` = 0 follow from that.

## Timing
- Request accepted at edge N; `busy` is high from N.
- MULTU and DIVU: HI/LO written at edge N+32, `busy` low after N+32, `done` high for N+32..N+33.
- DIV: written at N+33 (includes FIX).
- Divide-by-zero: written at N+1.
- mthi/mtlo: written at N+1 with no busy period.
- MFHI/MFLO in the cycle right after completion reads the new value, with no stall.
- Back-to-back: a new start may be accepted on the cycle `busy` falls.

## Configuration
- `HILO_FAST_MULTU_EN` defined: MULTU uses a single-cycle XLEN×XLEN multiply. It takes the MUL state for exactly 1 cycle, so HI/LO are written at N+1.
- Undefined: iterative 32-cycle MULTU as above.
- Division is iterative in both cases.

## Structure
- Package `hilo_pkg` holds:
  - the state enum (IDLE/MUL/DIV/FIX/ZERO)
  - the op-select encoding
  - the `ITER_CNT` = 32 constant
  - the default `DIVZ_LO`
- Sub-module `muldiv_iter_core` is the per-iteration datapath: 64-bit accumulator, shift, add/subtract-compare. The controller FSM, counter, sign handling and HI/LO live in the top module.

## Test plan
- Reset with `rst_n` low mid-operation: `hi` = `lo` = 0 and `busy` = 0 immediately; `done` is never seen.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF: at N+32, HI = 0xFFFFFFFE and LO = 0x00000001. With `HILO_FAST_MULTU_EN`, the same values appear at N+1.
- DIV -7 / 2: at N+33, LO = 0xFFFFFFFD and HI = 0xFFFFFFFF. `done` is a single pulse.
- DIVU 100 / 0: at N+1, LO = 0xFFFFFFFF and HI = 0x00000064. DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000 and HI = 0.
- Hazards:
  - MTHI 0x1234 followed by MFHI: `rdata` = 0x1234 with no stall.
  - rd_lo asserted while DIVU runs: `stall` = 1 until completion.
  - An independent non-HI/LO cycle: `stall` = 0.
- Flush at iteration 10 of DIVU: IDLE next cycle, HI/LO keep their prior values, no `done`. A new MULTU is then accepted immediately.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
package hilo_pkg;

    localparam int          ITER_CNT        = 32;
    localparam int          CNT_W           = $clog2(ITER_CNT);
    localparam logic [31:0] DIVZ_LO_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_ZERO
    } state_e;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_MULTU,
        OP_DIV,
        OP_DIVU,
        OP_MTHI,
        OP_MTLO
    } op_sel_e;

    typedef enum logic {
        CORE_MUL,
        CORE_DIV
    } core_op_e;

    // Same-cycle request priority; flush is handled separately by the caller.
    function automatic op_sel_e decode_req(input logic div, input logic divu,
                                           input logic multu, input logic mthi,
                                           input logic mtlo);
        if (div)   return OP_DIV;
        if (divu)  return OP_DIVU;
        if (multu) return OP_MULTU;
        if (mthi)  return OP_MTHI;
        if (mtlo)  return OP_MTLO;
        return OP_NONE;
    endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// Execute-stage <-> HI/LO unit connection bundle.
interface hilo_muldiv_ctrl_if #(parameter int XLEN = 32);
    logic            start_multu;
    logic            start_div;
    logic            start_divu;
    logic            mthi;
    logic            mtlo;
    logic            rd_hi;
    logic            rd_lo;
    logic            flush;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] rdata;
    logic            busy;
    logic            stall;
    logic            done;

    modport master (
        output start_multu, start_div, start_divu, mthi, mtlo, rd_hi, rd_lo,
               flush, rs_val, rt_val,
        input  hi, lo, rdata, busy, stall, done
    );

    modport slave (
        input  start_multu, start_div, start_divu, mthi, mtlo, rd_hi, rd_lo,
               flush, rs_val, rt_val,
        output hi, lo, rdata, busy, stall, done
    );
endinterface

// File: rtl/muldiv_iter_core.sv
// One-bit-per-cycle multiply/divide datapath around a 2*XLEN accumulator.
// Multiply: acc = {partial, multiplier}, add-then-shift-right.
// Divide:   acc = {remainder, dividend/quotient}, shift-left-then-subtract.
module muldiv_iter_core
    import hilo_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  core_op_e          op,
    input  logic [2*XLEN-1:0] load_val,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc,
    output logic [2*XLEN-1:0] acc_nxt
);
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] rem_diff;
    logic            q_bit;

    // Next accumulator value for one iteration of the selected operation.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        rem_sh   = acc[2*XLEN-1:XLEN-1];
        q_bit    = (rem_sh >= {1'b0, operand});
        // Result is always below the divisor when used, so XLEN bits suffice.
        rem_diff = rem_sh[XLEN-1:0] - operand;
        acc_nxt  = acc;
        if (step) begin
            if (op == CORE_MUL)
                acc_nxt = {mul_sum, acc[XLEN-1:1]};
            else
                acc_nxt = {(q_bit ? rem_diff : rem_sh[XLEN-1:0]), acc[XLEN-2:0], q_bit};
        end
    end

    // Accumulator register: load on acceptance, otherwise follow the iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (load)
            acc <= load_val;
        else
            acc <= acc_nxt;
    end
endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: FSM, iteration counter, sign handling,
// architectural HI/LO and MFHI/MFLO read port.
// Build option HILO_FAST_MULTU_EN: single-cycle MULTU instead of 32 iterations.
//
// state | meaning
// IDLE  | accepts requests; MTHI/MTLO write directly
// MUL   | MULTU in progress (1 cycle in fast build)
// DIV   | restoring division on magnitudes, 32 iterations
// FIX   | DIV only: apply signs to quotient/remainder, write HI/LO
// ZERO  | divide-by-zero: write LO = DIVZ_LO, HI = dividend
module hilo_muldiv_ctrl
    import hilo_pkg::*;
#(
    parameter int              XLEN    = 32,
    parameter logic [XLEN-1:0] DIVZ_LO = XLEN'(DIVZ_LO_DEFAULT)
) (
    input  logic                clk,
    input  logic                rst_n,
    hilo_muldiv_ctrl_if.slave   bus
);
    state_e            state, state_nxt;
    op_sel_e           op_sel;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_tc;
    logic [XLEN-1:0]   hi_q, lo_q, op_a, op_b;
    logic              neg_q, neg_r, signed_op, done_q;
    logic              accept, rt_zero, is_sdiv, rs_neg, rt_neg;
    logic [XLEN-1:0]   rs_in, rt_in, q_mag, r_mag;
    logic              core_load, core_step;
    core_op_e          core_op;
    logic [2*XLEN-1:0] core_acc, core_acc_nxt;
    logic              hi_we, lo_we, op_done;
    logic [XLEN-1:0]   hi_nxt, lo_nxt;
`ifdef HILO_FAST_MULTU_EN
    logic [2*XLEN-1:0] product;
    assign product = (2*XLEN)'(op_a) * (2*XLEN)'(op_b);
`endif

    assign op_sel  = decode_req(bus.start_div, bus.start_divu, bus.start_multu,
                                bus.mthi, bus.mtlo);
    assign accept  = (state == ST_IDLE) && !bus.flush &&
                     ((op_sel == OP_MULTU) || (op_sel == OP_DIV) || (op_sel == OP_DIVU));
    assign rt_zero = (bus.rt_val == '0);
    assign is_sdiv = (op_sel == OP_DIV);
    assign rs_neg  = is_sdiv && bus.rs_val[XLEN-1];
    assign rt_neg  = is_sdiv && bus.rt_val[XLEN-1];
    assign rs_in   = rs_neg ? -bus.rs_val : bus.rs_val;
    assign rt_in   = rt_neg ? -bus.rt_val : bus.rt_val;
    assign cnt_tc  = (cnt == '0);
    assign q_mag   = core_acc[XLEN-1:0];
    assign r_mag   = core_acc[2*XLEN-1:XLEN];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; flush always returns to IDLE.
    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (op_sel == OP_MULTU)
                        state_nxt = ST_MUL;
                    else if ((op_sel == OP_DIV) || (op_sel == OP_DIVU))
                        state_nxt = rt_zero ? ST_ZERO : ST_DIV;
                end
`ifdef HILO_FAST_MULTU_EN
                ST_MUL:  state_nxt = ST_IDLE;
`else
                ST_MUL:  if (cnt_tc) state_nxt = ST_IDLE;
`endif
                ST_DIV:  if (cnt_tc) state_nxt = signed_op ? ST_FIX : ST_IDLE;
                ST_FIX:  state_nxt = ST_IDLE;
                ST_ZERO: state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Per-state datapath controls and HI/LO write values; a flush suppresses all writes.
    always_comb begin
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        hi_nxt    = '0;
        lo_nxt    = '0;
        op_done   = 1'b0;
        core_load = 1'b0;
        core_step = 1'b0;
        core_op   = CORE_MUL;
        if (!bus.flush) begin
            case (state)
                ST_IDLE: begin
                    core_load = accept;
                    if (op_sel == OP_MTHI) begin
                        hi_we  = 1'b1;
                        hi_nxt = bus.rs_val;
                    end
                    if (op_sel == OP_MTLO) begin
                        lo_we  = 1'b1;
                        lo_nxt = bus.rs_val;
                    end
                end
                ST_MUL: begin
`ifdef HILO_FAST_MULTU_EN
                    {hi_nxt, lo_nxt} = product;
                    hi_we   = 1'b1;
                    lo_we   = 1'b1;
                    op_done = 1'b1;
`else
                    core_step = 1'b1;
                    if (cnt_tc) begin
                        {hi_nxt, lo_nxt} = core_acc_nxt;
                        hi_we   = 1'b1;
                        lo_we   = 1'b1;
                        op_done = 1'b1;
                    end
`endif
                end
                ST_DIV: begin
                    core_op   = CORE_DIV;
                    core_step = 1'b1;
                    if (cnt_tc && !signed_op) begin
                        {hi_nxt, lo_nxt} = core_acc_nxt;
                        hi_we   = 1'b1;
                        lo_we   = 1'b1;
                        op_done = 1'b1;
                    end
                end
                ST_FIX: begin
                    lo_nxt  = neg_q ? -q_mag : q_mag;
                    hi_nxt  = neg_r ? -r_mag : r_mag;
                    hi_we   = 1'b1;
                    lo_we   = 1'b1;
                    op_done = 1'b1;
                end
                ST_ZERO: begin
                    lo_nxt  = DIVZ_LO;
                    hi_nxt  = op_a;
                    hi_we   = 1'b1;
                    lo_we   = 1'b1;
                    op_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Iteration down-counter; terminal count marks the last iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (bus.flush)
            cnt <= '0;
        else if (accept)
            cnt <= CNT_W'(ITER_CNT - 1);
        else if (((state == ST_MUL) || (state == ST_DIV)) && !cnt_tc)
            cnt <= cnt - 1'b1;
    end

    // Architectural HI/LO, done pulse and operands/signs latched at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            signed_op <= 1'b0;
        end else begin
            if (hi_we) hi_q <= hi_nxt;
            if (lo_we) lo_q <= lo_nxt;
            done_q <= op_done;
            if (accept) begin
                op_a      <= bus.rs_val;
                op_b      <= rt_in;
                neg_q     <= rs_neg ^ rt_neg;
                neg_r     <= rs_neg;
                signed_op <= is_sdiv;
            end
        end
    end

    muldiv_iter_core #(.XLEN(XLEN)) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (core_load),
        .step     (core_step),
        .op       (core_op),
        .load_val ({{XLEN{1'b0}}, rs_in}),
        .operand  (op_b),
        .acc      (core_acc),
        .acc_nxt  (core_acc_nxt)
    );

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.done  = done_q;
    assign bus.busy  = (state != ST_IDLE);
    assign bus.stall = bus.busy && (bus.start_multu || bus.start_div || bus.start_divu ||
                                    bus.mthi || bus.mtlo || bus.rd_hi || bus.rd_lo);
    assign bus.rdata = bus.rd_hi ? hi_q : (bus.rd_lo ? lo_q : '0);
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl; expected HI/LO and latencies come
// from plain arithmetic on the operands.
module tb_hilo_muldiv_ctrl;
`ifdef HILO_FAST_MULTU_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 32;
`endif
    localparam int OP_MULTU = 0;
    localparam int OP_DIVU  = 1;
    localparam int OP_DIV   = 2;
    localparam logic [31:0] DIVZ = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    hilo_muldiv_ctrl_if #(.XLEN(32)) bus ();

    hilo_muldiv_ctrl #(.XLEN(32), .DIVZ_LO(32'hFFFF_FFFF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model(input int op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] ehi, output logic [31:0] elo,
                                  output int elat);
        logic [63:0] p;
        longint      sa, sb, q, r;
        if (op == OP_MULTU) begin
            p    = 64'(a) * 64'(b);
            ehi  = p[63:32];
            elo  = p[31:0];
            elat = MUL_LAT;
        end else if (b == 32'd0) begin
            ehi  = a;
            elo  = DIVZ;
            elat = 1;
        end else if (op == OP_DIVU) begin
            ehi  = a % b;
            elo  = a / b;
            elat = 32;
        end else begin
            sa   = longint'($signed(a));
            sb   = longint'($signed(b));
            q    = sa / sb;
            r    = sa % sb;
            ehi  = r[31:0];
            elo  = q[31:0];
            elat = 33;
        end
    endfunction

    task automatic clear_inputs();
        bus.start_multu = 1'b0;
        bus.start_div   = 1'b0;
        bus.start_divu  = 1'b0;
        bus.mthi        = 1'b0;
        bus.mtlo        = 1'b0;
        bus.rd_hi       = 1'b0;
        bus.rd_lo       = 1'b0;
        bus.flush       = 1'b0;
        bus.rs_val      = '0;
        bus.rt_val      = '0;
    endtask

    task automatic drive_start(input int op, input logic [31:0] a, input logic [31:0] b);
        bus.start_multu = (op == OP_MULTU);
        bus.start_divu  = (op == OP_DIVU);
        bus.start_div   = (op == OP_DIV);
        bus.rs_val      = a;
        bus.rt_val      = b;
    endtask

    // Issue one operation and measure done latency, pulse width and the written HI/LO.
    task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int width, output logic [31:0] ohi,
                          output logic [31:0] olo, output logic busy_acc);
        @(negedge clk);
        drive_start(op, a, b);
        @(posedge clk); #1;
        busy_acc = bus.busy;
        bus.start_multu = 1'b0;
        bus.start_divu  = 1'b0;
        bus.start_div   = 1'b0;
        bus.rs_val      = $urandom;
        bus.rt_val      = $urandom;
        lat = -1;
        ohi = '0;
        olo = '0;
        for (int k = 1; k <= 40; k++) begin
            if (lat < 0) begin
                @(posedge clk); #1;
                if (bus.done) begin
                    lat = k;
                    ohi = bus.hi;
                    olo = bus.lo;
                end
            end
        end
        width = 0;
        if (lat > 0) begin
            width = 1;
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;
                if (bus.done) width++;
            end
        end
    endtask

    task automatic test_reset();
        logic seen_done;
        clear_inputs();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b expected all zero",
                     bus.hi, bus.lo, bus.busy, bus.done);
        end
        bus.rd_hi = 1'b1;
        #1;
        checks++;
        if (bus.rdata !== 32'd0 || bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_rdata: rdata=%h stall=%b expected 0/0", bus.rdata, bus.stall);
        end
        bus.rd_hi = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); bus.mthi = 1'b1; bus.rs_val = 32'hAAAA_5555;
        @(negedge clk); bus.mthi = 1'b0; bus.mtlo = 1'b1; bus.rs_val = 32'h5555_AAAA;
        @(negedge clk); bus.mtlo = 1'b0;
        drive_start(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
        @(posedge clk); #1;
        bus.start_multu = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_midop: hi=%h lo=%h busy=%b expected 0/0/0",
                     bus.hi, bus.lo, bus.busy);
        end
        @(negedge clk); rst_n = 1'b1;
        seen_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.done) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_done: done seen=%b expected 0", seen_done);
        end
    endtask

    task automatic test_multu();
        int lat, width;
        logic [31:0] h, l;
        logic ba;
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, width, h, l, ba);
        checks++;
        if (lat != MUL_LAT || width != 1 || ba !== 1'b1) begin
            failures++;
            $display("FAIL multu_timing: lat=%0d width=%0d busy=%b expected %0d/1/1",
                     lat, width, ba, MUL_LAT);
        end
        checks++;
        if (h !== 32'hFFFF_FFFE || l !== 32'h0000_0001) begin
            failures++;
            $display("FAIL multu_max: hi=%h lo=%h expected fffffffe/00000001", h, l);
        end
    endtask

    task automatic test_div_signed();
        int lat, width;
        logic [31:0] h, l;
        logic ba;
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, width, h, l, ba);
        checks++;
        if (lat != 33 || width != 1 || h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFD) begin
            failures++;
            $display("FAIL div_m7_2: lat=%0d width=%0d hi=%h lo=%h expected 33/1/ffffffff/fffffffd",
                     lat, width, h, l);
        end
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, width, h, l, ba);
        checks++;
        if (lat != 33 || h !== 32'h0 || l !== 32'h8000_0000) begin
            failures++;
            $display("FAIL div_minint: lat=%0d hi=%h lo=%h expected 33/00000000/80000000",
                     lat, h, l);
        end
    endtask

    task automatic test_div_zero();
        int lat, width;
        logic [31:0] h, l;
        logic ba;
        run_op(OP_DIVU, 32'd100, 32'd0, lat, width, h, l, ba);
        checks++;
        if (lat != 1 || width != 1 || h !== 32'h64 || l !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL divu_zero: lat=%0d width=%0d hi=%h lo=%h expected 1/1/00000064/ffffffff",
                     lat, width, h, l);
        end
        run_op(OP_DIV, 32'hFFFF_FF00, 32'd0, lat, width, h, l, ba);
        checks++;
        if (lat != 1 || h !== 32'hFFFF_FF00 || l !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL div_zero: lat=%0d hi=%h lo=%h expected 1/ffffff00/ffffffff", lat, h, l);
        end
    endtask

    task automatic test_move_hazard();
        @(negedge clk);
        bus.mthi = 1'b1; bus.rs_val = 32'h1234;
        @(posedge clk); #1;
        bus.mthi = 1'b0; bus.rd_hi = 1'b1; bus.rs_val = $urandom;
        #1;
        checks++;
        if (bus.rdata !== 32'h1234 || bus.stall !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL mthi_mfhi: rdata=%h stall=%b busy=%b expected 00001234/0/0",
                     bus.rdata, bus.stall, bus.busy);
        end
        @(negedge clk);
        bus.rd_hi = 1'b0; bus.mtlo = 1'b1; bus.rs_val = 32'h5678;
        @(posedge clk); #1;
        bus.mtlo = 1'b0; bus.rd_lo = 1'b1;
        #1;
        checks++;
        if (bus.rdata !== 32'h5678 || bus.hi !== 32'h1234) begin
            failures++;
            $display("FAIL mtlo_mflo: rdata=%h hi=%h expected 00005678/00001234", bus.rdata, bus.hi);
        end
        bus.rd_lo = 1'b0;
        #1;
        checks++;
        if (bus.rdata !== 32'd0) begin
            failures++;
            $display("FAIL rdata_idle: rdata=%h expected 00000000", bus.rdata);
        end
    endtask

    task automatic test_stall();
        logic [31:0] eh, el;
        int elat, fin, bad;
        model(OP_DIVU, 32'd1000, 32'd7, eh, el, elat);
        @(negedge clk);
        drive_start(OP_DIVU, 32'd1000, 32'd7);
        @(posedge clk); #1;
        bus.start_divu = 1'b0;
        bus.rs_val = $urandom;
        bus.rt_val = $urandom;
        #1;
        checks++;
        if (bus.busy !== 1'b1 || bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL stall_independent: busy=%b stall=%b expected 1/0", bus.busy, bus.stall);
        end
        bus.rd_lo = 1'b1;
        fin = -1;
        bad = 0;
        for (int k = 1; k <= 40; k++) begin
            if (fin < 0) begin
                #1;
                if (bus.busy && bus.stall !== 1'b1) bad++;
                @(posedge clk); #1;
                if (!bus.busy) fin = k;
            end
        end
        checks++;
        if (bad != 0 || fin != elat) begin
            failures++;
            $display("FAIL stall_held: bad_cycles=%0d busy_fell_at=%0d expected 0/%0d", bad, fin, elat);
        end
        checks++;
        if (bus.stall !== 1'b0 || bus.rdata !== el || bus.hi !== eh) begin
            failures++;
            $display("FAIL mflo_after_done: stall=%b rdata=%h hi=%h expected 0/%h/%h",
                     bus.stall, bus.rdata, bus.hi, el, eh);
        end
        bus.rd_lo = 1'b0;
    endtask

    task automatic test_flush();
        int lat, width;
        logic [31:0] h, l, eh, el;
        logic ba, seen_done;
        int elat;
        @(negedge clk); bus.mthi = 1'b1; bus.rs_val = 32'h1111_2222;
        @(negedge clk); bus.mthi = 1'b0; bus.mtlo = 1'b1; bus.rs_val = 32'h3333_4444;
        @(negedge clk); bus.mtlo = 1'b0;
        drive_start(OP_DIVU, 32'd50000, 32'd3);
        @(posedge clk); #1;
        bus.start_divu = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'h1111_2222 || bus.lo !== 32'h3333_4444) begin
            failures++;
            $display("FAIL flush_iter10: busy=%b hi=%h lo=%h expected 0/11112222/33334444",
                     bus.busy, bus.hi, bus.lo);
        end
        seen_done = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (bus.done) seen_done = 1'b1;
            @(posedge clk); #1;
        end
        if (bus.done) seen_done = 1'b1;
        checks++;
        if (seen_done !== 1'b0) begin
            failures++;
            $display("FAIL flush_no_done: done seen=%b expected 0", seen_done);
        end
        model(OP_MULTU, 32'h0001_0003, 32'h0002_0005, eh, el, elat);
        run_op(OP_MULTU, 32'h0001_0003, 32'h0002_0005, lat, width, h, l, ba);
        checks++;
        if (ba !== 1'b1 || lat != elat || h !== eh || l !== el) begin
            failures++;
            $display("FAIL flush_then_multu: busy=%b lat=%0d hi=%h lo=%h expected 1/%0d/%h/%h",
                     ba, lat, h, l, elat, eh, el);
        end
        drive_start(OP_DIVU, 32'd77, 32'd5);
        @(posedge clk); #1;
        bus.start_divu = 1'b0;
        repeat (31) @(posedge clk);
        @(negedge clk); bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        seen_done = bus.done;
        @(posedge clk); #1;
        if (bus.done) seen_done = 1'b1;
        checks++;
        if (seen_done !== 1'b0 || bus.busy !== 1'b0 || bus.hi !== eh || bus.lo !== el) begin
            failures++;
            $display("FAIL flush_on_completion: done=%b busy=%b hi=%h lo=%h expected 0/0/%h/%h",
                     seen_done, bus.busy, bus.hi, bus.lo, eh, el);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] eh1, el1, eh2, el2;
        int elat1, elat2, lat1, lat2;
        logic [31:0] a1, b1, a2, b2;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom_range(1, 1000);
        model(OP_MULTU, a1, b1, eh1, el1, elat1);
        model(OP_DIVU, a2, b2, eh2, el2, elat2);
        @(negedge clk);
        drive_start(OP_MULTU, a1, b1);
        @(posedge clk); #1;
        bus.start_multu = 1'b0;
        lat1 = -1;
        for (int k = 1; k <= 40; k++) begin
            if (lat1 < 0) begin
                @(posedge clk); #1;
                if (bus.done) lat1 = k;
            end
        end
        bus.rd_hi = 1'b1;
        drive_start(OP_DIVU, a2, b2);
        #1;
        checks++;
        if (lat1 != elat1 || bus.rdata !== eh1 || bus.stall !== 1'b0 || bus.lo !== el1) begin
            failures++;
            $display("FAIL b2b_first: lat=%0d rdata=%h stall=%b lo=%h expected %0d/%h/0/%h",
                     lat1, bus.rdata, bus.stall, bus.lo, elat1, eh1, el1);
        end
        @(posedge clk); #1;
        bus.start_divu = 1'b0;
        bus.rd_hi = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept: busy=%b expected 1", bus.busy);
        end
        lat2 = -1;
        for (int k = 1; k <= 40; k++) begin
            if (lat2 < 0) begin
                @(posedge clk); #1;
                if (bus.done) lat2 = k;
            end
        end
        checks++;
        if (lat2 != elat2 || bus.hi !== eh2 || bus.lo !== el2) begin
            failures++;
            $display("FAIL b2b_second: lat=%0d hi=%h lo=%h expected %0d/%h/%h",
                     lat2, bus.hi, bus.lo, elat2, eh2, el2);
        end
    endtask

    task automatic test_random();
        int op, lat, width, elat;
        logic [31:0] a, b, h, l, eh, el;
        logic ba;
        for (int i = 0; i < 24; i++) begin
            op = $urandom_range(0, 2);
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            model(op, a, b, eh, el, elat);
            run_op(op, a, b, lat, width, h, l, ba);
            checks++;
            if (lat != elat || width != 1 || ba !== 1'b1) begin
                failures++;
                $display("FAIL rand_timing[%0d] op=%0d a=%h b=%h: lat=%0d width=%0d busy=%b expected %0d/1/1",
                         i, op, a, b, lat, width, ba, elat);
            end
            checks++;
            if (h !== eh || l !== el) begin
                failures++;
                $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: hi=%h lo=%h expected %h/%h",
                         i, op, a, b, h, l, eh, el);
            end
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_div_signed();
        test_div_zero();
        test_move_hazard();
        test_stall();
        test_flush();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
